// File: rtl/ps2_scancode_rx_if.sv
// PS/2 receiver bus: raw device pins in, scan-code history and status out.
// master = PS/2 device side (drives pins); slave = receiver side (drives results).
interface ps2_scancode_rx_if;
  logic        PS2_CLK;
  logic        PS2_DATA;
  logic [15:0] KBBuffer;
  logic        NewCode;
  logic        FrameErr;
  logic [7:0]  ErrCount;

  modport master (
    output PS2_CLK,
    output PS2_DATA,
    input  KBBuffer,
    input  NewCode,
    input  FrameErr,
    input  ErrCount
  );

  modport slave (
    input  PS2_CLK,
    input  PS2_DATA,
    output KBBuffer,
    output NewCode,
    output FrameErr,
    output ErrCount
  );
endinterface

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: sync + glitch filter, 11-bit frame FSM, two-code history.
// Ports: CLK, RESET (async high), bus (slave: pins in; KBBuffer/NewCode/FrameErr/ErrCount out).
module ps2_scancode_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic          CLK,
  input  logic          RESET,
  ps2_scancode_rx_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] F_LAST = 8'(FILTER_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state, state_nx;

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          clk_s;
  logic          data_s;
  logic          filt;
  logic [7:0]    fcnt;
  logic          flip;
  logic          fall;
  logic [TW-1:0] tcnt;
  logic          tmo;
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic          frame_ok;
  logic          new_code_d;
  logic          frame_err_d;
  logic [15:0]   kb_q;
  logic          new_code_q;
  logic          frame_err_q;
  logic [7:0]    err_cnt_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], bus.PS2_CLK};
      data_sync <= {data_sync[0], bus.PS2_DATA};
    end
  end

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];

  // fcnt counts consecutive samples that disagree with filt
  assign flip = (clk_s != filt) && (fcnt == F_LAST);
  assign fall = flip && filt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      filt <= 1'b1;
      fcnt <= 8'd0;
    end else if (clk_s == filt) begin
      fcnt <= 8'd0;
    end else if (flip) begin
      filt <= clk_s;
      fcnt <= 8'd0;
    end else begin
      fcnt <= fcnt + 8'd1;
    end
  end

  // a falling edge in the same cycle wins over the abort
  assign tmo = (state != IDLE) && !fall && (tcnt == T_LAST);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      tcnt <= '0;
    end else if (state == IDLE || fall || tmo) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + TW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (fall && !data_s) state_nx = DATA;
      end
      DATA: begin
        if (tmo) state_nx = IDLE;
        else if (fall && bit_cnt == 4'd7) state_nx = PARITY;
      end
      PARITY: begin
        if (tmo) state_nx = IDLE;
        else if (fall) state_nx = STOP;
      end
      STOP: begin
        if (tmo || fall) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // odd parity: XOR of all nine bits is 1
  assign frame_ok = data_s && (^{shreg, par_bit});

  always_comb begin
    new_code_d  = 1'b0;
    frame_err_d = tmo;
    if (state == STOP && fall) begin
      new_code_d  = frame_ok;
      frame_err_d = !frame_ok;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      bit_cnt <= 4'd0;
      shreg   <= 8'd0;
      par_bit <= 1'b0;
    end else if (fall) begin
      if (state == IDLE) begin
        bit_cnt <= 4'd0;
      end else if (state == DATA) begin
        shreg   <= {data_s, shreg[7:1]};
        bit_cnt <= bit_cnt + 4'd1;
      end else if (state == PARITY) begin
        par_bit <= data_s;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      kb_q        <= 16'h0000;
      new_code_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= 8'd0;
    end else begin
      new_code_q  <= new_code_d;
      frame_err_q <= frame_err_d;
      if (new_code_d) kb_q <= {kb_q[7:0], shreg};
      if (frame_err_d && err_cnt_q != 8'hFF) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign bus.KBBuffer = kb_q;
  assign bus.NewCode  = new_code_q;
  assign bus.FrameErr = frame_err_q;
  assign bus.ErrCount = err_cnt_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Self-checking bench for ps2_scancode_rx: directed + random frames vs a byte-level model.
// Ports: none (drives the bus interface master side, clocks CLK at 100 MHz).
module tb_ps2_scancode_rx;

  localparam int HALF = 16;
  localparam int TMO  = 80;

  logic CLK = 1'b0;
  logic RESET;

  int checks    = 0;
  int failures  = 0;
  int nc_seen   = 0;
  int fe_seen   = 0;
  int both_seen = 0;

  logic [15:0] m_kb;
  logic [7:0]  m_ec;
  int          m_nc;
  int          m_fe;

  ps2_scancode_rx_if bus();

  ps2_scancode_rx #(
    .FILTER_LEN(8),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    #1;
    if (bus.NewCode === 1'b1) nc_seen++;
    if (bus.FrameErr === 1'b1) fe_seen++;
    if (bus.NewCode === 1'b1 && bus.FrameErr === 1'b1) both_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge CLK);
  endtask

  task automatic send_bit(input logic b);
    bus.PS2_DATA = b;
    cycles(HALF);
    bus.PS2_CLK = 1'b0;
    cycles(HALF);
    bus.PS2_CLK = 1'b1;
  endtask

  task automatic glitch();
    cycles(4);
    bus.PS2_CLK = 1'b0;
    cycles(5);
    bus.PS2_CLK = 1'b1;
    cycles(4);
  endtask

  task automatic m_err();
    m_fe++;
    if (m_ec != 8'hFF) m_ec = m_ec + 8'd1;
  endtask

  // full frame; glitch_at = index of frame bit preceded by a clock glitch, -1 none
  task automatic frame(input logic [7:0] b, input bit bad_par,
                       input bit bad_stop, input int glitch_at);
    logic [10:0] bits;
    logic p;
    p = (($countones(b) % 2) == 0) ? 1'b1 : 1'b0;
    p = p ^ bad_par;
    bits = {~bad_stop, p, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      if (i == glitch_at) glitch();
      send_bit(bits[i]);
    end
    bus.PS2_DATA = 1'b1;
    cycles(HALF);
    if (!bad_par && !bad_stop) begin
      m_kb = {m_kb[7:0], b};
      m_nc++;
    end else begin
      m_err();
    end
  endtask

  task automatic partial(input logic [7:0] b, input int n);
    send_bit(1'b0);
    for (int i = 0; i < n; i++) send_bit(b[i]);
    bus.PS2_DATA = 1'b1;
  endtask

  task automatic check_state(input string tag);
    @(negedge CLK);
    chk({tag, ".kb"}, 32'(bus.KBBuffer), 32'(m_kb));
    chk({tag, ".ec"}, 32'(bus.ErrCount), 32'(m_ec));
    chk({tag, ".nc"}, nc_seen, m_nc);
    chk({tag, ".fe"}, fe_seen, m_fe);
  endtask

  initial begin
    logic [7:0] rb;
    int r;
    m_kb = 16'h0000;
    m_ec = 8'd0;
    m_nc = 0;
    m_fe = 0;
    RESET = 1'b1;
    bus.PS2_CLK = 1'b1;
    bus.PS2_DATA = 1'b1;
    cycles(3);
    @(negedge CLK);
    chk("rst.kb", 32'(bus.KBBuffer), 32'h0);
    chk("rst.nc", 32'(bus.NewCode), 32'h0);
    chk("rst.fe", 32'(bus.FrameErr), 32'h0);
    chk("rst.ec", 32'(bus.ErrCount), 32'h0);
    RESET = 1'b0;
    cycles(HALF);

    frame(8'h05, 0, 0, -1);
    check_state("t1");
    frame(8'hF0, 0, 0, -1);
    check_state("t2a");
    frame(8'h05, 0, 0, -1);
    check_state("t2b");

    frame(8'h5A, 1, 0, -1);
    check_state("t3par");
    frame(8'h16, 0, 1, -1);
    check_state("t3stop");

    glitch();
    cycles(HALF);
    check_state("t4idle");
    frame(8'h16, 0, 0, 4);
    check_state("t4mid");

    partial(8'h1E, 4);
    cycles(3 * TMO);
    m_err();
    check_state("t5tmo");
    frame(8'h1E, 0, 0, -1);
    check_state("t5rx");

    partial(8'h77, 6);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    chk("t6.kb", 32'(bus.KBBuffer), 32'h0);
    chk("t6.ec", 32'(bus.ErrCount), 32'h0);
    chk("t6.nc", 32'(bus.NewCode), 32'h0);
    chk("t6.fe", 32'(bus.FrameErr), 32'h0);
    m_kb = 16'h0000;
    m_ec = 8'd0;
    cycles(5);
    @(negedge CLK);
    RESET = 1'b0;
    cycles(HALF);
    frame(8'h45, 0, 0, -1);
    check_state("t6rx");

    for (int k = 0; k < 12; k++) begin
      rb = 8'($urandom);
      r = int'($urandom_range(0, 3));
      frame(rb, r == 1, r == 2, -1);
      check_state($sformatf("rnd%0d", k));
    end

    for (int k = 0; k < 256; k++) begin
      partial(8'h00, 0);
      cycles(TMO + 40);
      m_err();
    end
    check_state("sat");
    chk("sat.ff", 32'(bus.ErrCount), 32'hFF);

    frame(8'hAB, 0, 0, -1);
    check_state("post");
    chk("excl", both_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
